// File: rtl/fp_mul_round_pack.sv
// Normalize / round / pack back end for the binary32 multiplier.
// Two registered stages with a valid/ready handshake on both sides.
module fp_mul_round_pack #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic [1:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  logic               s1_valid;
  logic               s1_sign;
  logic [1:0]         s1_class;
  logic [23:0]        s1_m;
  logic               s1_g;
  logic               s1_r;
  logic               s1_s;
  logic signed [10:0] s1_e;

  logic adv2;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  logic [23:0]        norm_m;
  logic               norm_g;
  logic               norm_r;
  logic               norm_s;
  logic signed [10:0] norm_e;
  logic signed [10:0] exp_ext;

  assign exp_ext = {in_exp[9], in_exp};

  // Product is in [1,4): a set bit 47 means one extra integer bit to shift out.
  always_comb begin
    if (in_mant[47]) begin
      norm_m = in_mant[47:24];
      norm_g = in_mant[23];
      norm_r = in_mant[22];
      norm_s = |in_mant[21:0];
      norm_e = exp_ext + 11'sd1;
    end else begin
      norm_m = in_mant[46:23];
      norm_g = in_mant[22];
      norm_r = in_mant[21];
      norm_s = |in_mant[20:0];
      norm_e = exp_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_class <= 2'b00;
      s1_m     <= 24'd0;
      s1_g     <= 1'b0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= 11'sd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_class <= in_class;
        s1_m     <= norm_m;
        s1_g     <= norm_g;
        s1_r     <= norm_r;
        s1_s     <= norm_s;
        s1_e     <= norm_e;
      end
    end
  end

  logic               rnd_inc;
  logic [24:0]        m25;
  logic [22:0]        rnd_frac;
  logic signed [10:0] rnd_e;
  logic [31:0]        res_next;
  logic               ovf_next;
  logic               unf_next;
  logic               inx_next;

  always_comb begin
    rnd_inc = (ROUND_MODE == 0) ? (s1_g & (s1_r | s1_s | s1_m[0])) : 1'b0;
    m25     = {1'b0, s1_m} + {24'd0, rnd_inc};
    if (m25[24]) begin
      rnd_frac = m25[23:1];
      rnd_e    = s1_e + 11'sd1;
    end else begin
      rnd_frac = m25[22:0];
      rnd_e    = s1_e;
    end

    res_next = {s1_sign, rnd_e[7:0], rnd_frac};
    ovf_next = 1'b0;
    unf_next = 1'b0;
    inx_next = s1_g | s1_r | s1_s;

    case (s1_class)
      CLS_ZERO: begin
        res_next = {s1_sign, 31'd0};
        inx_next = 1'b0;
      end
      CLS_INF: begin
        res_next = {s1_sign, 8'hFF, 23'd0};
        inx_next = 1'b0;
      end
      CLS_NAN: begin
        res_next = 32'h7FC0_0000;
        inx_next = 1'b0;
      end
      default: begin
        // Underflow judged on the pre-round exponent so a carry cannot rescue it.
        if (s1_e <= 11'sd0) begin
          res_next = {s1_sign, 31'd0};
          unf_next = 1'b1;
          inx_next = 1'b1;
        end else if (rnd_e >= 11'sd255) begin
          res_next = {s1_sign, 8'hFF, 23'd0};
          ovf_next = 1'b1;
          inx_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_next;
        out_overflow  <= ovf_next;
        out_underflow <= unf_next;
        out_inexact   <= inx_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Bench for fp_mul_round_pack: directed vector table, backpressure and reset
// sequences, then random traffic scored against an arithmetic reference model.
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [1:0]  in_class;
  logic        out_ready;

  logic        in_ready, out_valid, out_overflow, out_underflow, out_inexact;
  logic [31:0] out_result;
  logic        t_in_ready, t_out_valid, t_out_overflow, t_out_underflow, t_out_inexact;
  logic [31:0] t_out_result;

  always #5 clk = ~clk;

  fp_mul_round_pack #(.ROUND_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  fp_mul_round_pack #(.ROUND_MODE(1)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_class(in_class),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_result(t_out_result),
    .out_overflow(t_out_overflow), .out_underflow(t_out_underflow), .out_inexact(t_out_inexact)
  );

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic [1:0]  cls;
    logic [31:0] r0;
    logic [2:0]  f0;
    logic [31:0] r1;
    logic [2:0]  f1;
  } vec_t;

  vec_t vecs[15];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic        last_acc;
  logic        prev_stall;
  logic [34:0] prev_word;
  logic [34:0] q0[$];
  logic [34:0] q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued rounding decision on the discarded remainder.
  function automatic logic [34:0] model(input logic sign, input logic [9:0] exp,
                                        input logic [47:0] mant, input logic [1:0] cls,
                                        input int mode);
    longint unsigned mv, kept, rem, half;
    int sh, e;
    logic ix, up;
    if (cls == 2'b01) return {sign, 31'd0, 3'b000};
    if (cls == 2'b10) return {sign, 8'hFF, 23'd0, 3'b000};
    if (cls == 2'b11) return {32'h7FC0_0000, 3'b000};
    mv = 64'(mant);
    e  = int'($signed(exp));
    if (mv >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    kept = mv >> sh;
    rem  = mv - (kept << sh);
    half = 64'd1 << (sh - 1);
    ix   = (rem != 0);
    up   = (mode == 0) && ((rem > half) || (rem == half && (kept % 2 == 1)));
    if (e <= 0) return {sign, 31'd0, 3'b011};
    if (up) kept = kept + 1;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0, 3'b101};
    return {sign, 8'(e), 23'(kept), 2'b00, ix};
  endfunction

  // Samples handshakes mid-cycle, i.e. the values the next rising edge will see.
  task automatic monitor();
    logic [34:0] cur, cur_t, expv;
    if (!rst_n) return;
    cur   = {out_result, out_overflow, out_underflow, out_inexact};
    cur_t = {t_out_result, t_out_overflow, t_out_underflow, t_out_inexact};
    check("ready_match", {63'd0, t_in_ready}, {63'd0, in_ready});
    if (prev_stall) check("hold_stable", 64'(cur), 64'(prev_word));
    if (out_valid && out_ready) begin
      if (q0.size() == 0) check("unexpected_out_rne", 64'd1, 64'd0);
      else begin
        expv = q0.pop_front();
        check("sb_rne", 64'(cur), 64'(expv));
      end
    end
    if (t_out_valid && out_ready) begin
      if (q1.size() == 0) check("unexpected_out_trunc", 64'd1, 64'd0);
      else begin
        expv = q1.pop_front();
        check("sb_trunc", 64'(cur_t), 64'(expv));
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      q0.push_back(model(in_sign, in_exp, in_mant, in_class, 0));
      q1.push_back(model(in_sign, in_exp, in_mant, in_class, 1));
      n_acc++;
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = cur;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int i);
    in_sign  = vecs[i].sign;
    in_exp   = vecs[i].exp;
    in_mant  = vecs[i].mant;
    in_class = vecs[i].cls;
    in_valid = 1'b1;
  endtask

  task automatic apply_vec(input int i);
    drive_vec(i);
    out_ready = 1'b1;
    #1;
    check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check($sformatf("v%0d_lat1", i), {63'd0, out_valid}, 64'd0);
    tick();
    check($sformatf("v%0d_lat2", i), {63'd0, out_valid}, 64'd1);
    check($sformatf("v%0d_rne", i), {29'd0, out_result, out_overflow, out_underflow, out_inexact},
          {29'd0, vecs[i].r0, vecs[i].f0});
    check($sformatf("v%0d_trunc", i), {29'd0, t_out_result, t_out_overflow, t_out_underflow, t_out_inexact},
          {29'd0, vecs[i].r1, vecs[i].f1});
  endtask

  task automatic rand_beat();
    logic [23:0] a, b;
    int ev, pick;
    pick     = $urandom_range(0, 19);
    in_sign  = 1'($urandom_range(0, 1));
    in_class = (pick == 0) ? 2'b01 : (pick == 1) ? 2'b10 : (pick == 2) ? 2'b11 : 2'b00;
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    in_mant = 48'(a) * 48'(b);
    if ($urandom_range(0, 3) == 0) begin
      if (in_mant[47]) in_mant[22:0] = 23'd0;
      else in_mant[21:0] = 22'd0;
    end
    case ($urandom_range(0, 2))
      0: ev = $urandom_range(0, 507) - 126;
      1: ev = $urandom_range(100, 160);
      default: begin
        ev = $urandom_range(0, 5);
        ev = (ev < 3) ? ev - 1 : ev + 250;
      end
    endcase
    in_exp = 10'(ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 2'b00, 32'h3F80_0000, 3'b000, 32'h3F80_0000, 3'b000};
    vecs[1]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 2'b00, 32'h4010_0000, 3'b000, 32'h4010_0000, 3'b000};
    vecs[2]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 3'b001, 32'h3F80_0000, 3'b001};
    vecs[3]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 3'b001, 32'h3F80_0001, 3'b001};
    vecs[4]  = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'b00, 32'h4000_0000, 3'b001, 32'h3FFF_FFFF, 3'b001};
    vecs[5]  = '{1'b0, 10'd254, 48'h9000_0000_0000, 2'b00, 32'h7F80_0000, 3'b101, 32'h7F80_0000, 3'b101};
    vecs[6]  = '{1'b0, 10'd0,   48'h4000_0000_0000, 2'b00, 32'h0000_0000, 3'b011, 32'h0000_0000, 3'b011};
    vecs[7]  = '{1'b1, 10'd127, 48'h0000_0000_0000, 2'b01, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b000};
    vecs[8]  = '{1'b1, 10'd5,   48'h0000_0000_0000, 2'b11, 32'h7FC0_0000, 3'b000, 32'h7FC0_0000, 3'b000};
    vecs[9]  = '{1'b1, 10'd0,   48'h0000_0000_0000, 2'b10, 32'hFF80_0000, 3'b000, 32'hFF80_0000, 3'b000};
    vecs[10] = '{1'b0, 10'd254, 48'h7FFF_FFC0_0000, 2'b00, 32'h7F80_0000, 3'b101, 32'h7F7F_FFFF, 3'b001};
    vecs[11] = '{1'b0, 10'd0,   48'h7FFF_FFC0_0000, 2'b00, 32'h0000_0000, 3'b011, 32'h0000_0000, 3'b011};
    vecs[12] = '{1'b1, 10'd127, 48'h4000_0000_0000, 2'b00, 32'hBF80_0000, 3'b000, 32'hBF80_0000, 3'b000};
    vecs[13] = '{1'b0, 10'h3FF, 48'h9000_0000_0000, 2'b00, 32'h0000_0000, 3'b011, 32'h0000_0000, 3'b011};
    vecs[14] = '{1'b0, 10'd253, 48'h9000_0000_0000, 2'b00, 32'h7F10_0000, 3'b000, 32'h7F10_0000, 3'b000};

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 10'd0;
    in_mant = 48'd0; in_class = 2'b00; out_ready = 1'b0;
    last_acc = 1'b0; prev_stall = 1'b0; prev_word = 35'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_word", {29'd0, out_result, out_overflow, out_underflow, out_inexact}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 15; i++) apply_vec(i);

    // Backpressure: two beats fill the pipe, third waits for out_ready.
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    drive_vec(0); #1; check("bp_accept_a", {63'd0, in_ready}, 64'd1); tick();
    drive_vec(1); #1; check("bp_accept_b", {63'd0, in_ready}, 64'd1); tick();
    drive_vec(3); #1; check("bp_full", {63'd0, in_ready}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp_hold_result", {32'd0, out_result}, 64'h3F80_0000);
      check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_comb_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second", {32'd0, out_result}, 64'h4010_0000);
    tick();
    check("bp_third", {32'd0, out_result}, 64'h3F80_0002);
    tick();
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive_vec(0); tick();
    drive_vec(1); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_result", {32'd0, out_result}, 64'd0);
    q0.delete(); q1.delete();
    prev_stall = 1'b0; last_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", {63'd0, in_ready}, 64'd1);
    apply_vec(0);

    // Random traffic with random backpressure.
    n_acc = 0;
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int c = 0; c < 4000 && n_acc < 400; c++) begin
      if (!in_valid || last_acc) begin
        if ($urandom_range(0, 9) < 7) begin
          rand_beat();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    check("random_progress", 64'(n_acc >= 400), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q0.size() != 0 || out_valid); c++) tick();
    check("drain_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
